if_fetch_unit: RTL and testbench

Instruction-fetch stage for the RVX pipeline. It holds the program counter and issues word fetches to instruction memory over a request/grant, in-order response bus, with up to two requests outstanding. Returned instructions are buffered in a 2-entry queue and drive the IF/ID pipeline register. The registered `jumpEn`/`jumpAddr` redirect from the jump/flush control unit is consumed here: the PC is reloaded, the queue is flushed, and stale responses are discarded.

---
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus: request/grant issue side, in-order response side.
interface if_fetch_unit_if #(
  parameter int BUS_W = 32
);
  logic             imemReq;
  logic [BUS_W-1:0] imemAddr;
  logic             imemGnt;
  logic             imemRvalid;
  logic [31:0]      imemRdata;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemGnt,
    input  imemRvalid,
    input  imemRdata
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemGnt,
    output imemRvalid,
    output imemRdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// RVX instruction fetch: PC, two-deep outstanding fetches, 2-entry queue, IF/ID register.
// Optional macro RVX_IF_MISALIGN_CHK_EN enables the misaligned redirect-target flag.
module if_fetch_unit #(
  parameter int               BUS_W    = 32,
  parameter logic [BUS_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  if_fetch_unit_if.master        imem,
  input  logic                   jumpEn,
  input  logic [BUS_W-1:0]       jumpAddr,
  input  logic                   stall,
  output logic [31:0]            instOut_IFID,
  output logic [BUS_W-1:0]       pcOut_IFID,
  output logic                   validOut_IFID,
  output logic                   misalignOut
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [BUS_W-1:0] pc_reg;
  logic [1:0]       out_cnt;
  logic [1:0]       kill_cnt;
  logic [1:0]       q_cnt;
  logic [1:0]       out_nxt;
  logic [1:0]       kill_nxt;
  logic [2:0]       slots;
  logic             req_fire;
  logic             pop;
  logic             push;
  logic [BUS_W-1:0] jump_tgt;

  // In-flight PC tags, one per granted request, consumed by every response
  logic [BUS_W-1:0] fly_pc [2];
  logic             fly_wr;
  logic             fly_rd;

  logic [31:0]      q_inst [2];
  logic [BUS_W-1:0] q_pc   [2];
  logic             q_wr;
  logic             q_rd;

  function automatic logic [BUS_W-1:0] align_word(input logic [BUS_W-1:0] a);
    return a & ~{{(BUS_W-2){1'b0}}, 2'b11};
  endfunction

  assign jump_tgt = align_word(jumpAddr);

  assign req_fire = imem.imemReq & imem.imemGnt;
  assign pop      = !stall && (q_cnt != 2'd0);
  assign push     = imem.imemRvalid && !jumpEn && (kill_cnt == 2'd0);
  assign slots    = {1'b0, q_cnt} + {1'b0, out_cnt} - {2'b00, pop};

  assign imem.imemReq  = (state == RUN) && !jumpEn && (slots < 3'd2);
  assign imem.imemAddr = pc_reg;

  always_comb begin
    out_nxt  = out_cnt + {1'b0, req_fire} - {1'b0, imem.imemRvalid};
    kill_nxt = kill_cnt;
    if (jumpEn)
      kill_nxt = out_nxt;
    else if (imem.imemRvalid && (kill_cnt != 2'd0))
      kill_nxt = kill_cnt - 2'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (jumpEn && (out_nxt != 2'd0)) state_nxt = DRAIN;
      DRAIN:   if (kill_nxt == 2'd0) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= BOOT;
    else
      state <= state_nxt;
  end

  // Fetch stage: PC, outstanding/kill accounting and tag pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg   <= RESET_PC;
      out_cnt  <= 2'd0;
      kill_cnt <= 2'd0;
      fly_wr   <= 1'b0;
      fly_rd   <= 1'b0;
    end else begin
      out_cnt  <= out_nxt;
      kill_cnt <= kill_nxt;
      if (jumpEn)
        pc_reg <= jump_tgt;
      else if (req_fire)
        pc_reg <= pc_reg + BUS_W'(4);
      if (req_fire)
        fly_wr <= ~fly_wr;
      if (imem.imemRvalid)
        fly_rd <= ~fly_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      fly_pc[fly_wr] <= pc_reg;
  end

  // Response stage: queue occupancy and pointers; a redirect empties it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_cnt <= 2'd0;
      q_wr  <= 1'b0;
      q_rd  <= 1'b0;
    end else if (jumpEn) begin
      q_cnt <= 2'd0;
      q_wr  <= 1'b0;
      q_rd  <= 1'b0;
    end else begin
      q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};
      if (push)
        q_wr <= ~q_wr;
      if (pop)
        q_rd <= ~q_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[q_wr] <= imem.imemRdata;
      q_pc[q_wr]   <= fly_pc[fly_rd];
    end
  end

  // IF/ID register: redirect beats stall, stall beats load/bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validOut_IFID <= 1'b0;
      instOut_IFID  <= NOP;
      pcOut_IFID    <= '0;
    end else if (jumpEn) begin
      validOut_IFID <= 1'b0;
      instOut_IFID  <= NOP;
    end else if (!stall) begin
      if (q_cnt != 2'd0) begin
        validOut_IFID <= 1'b1;
        instOut_IFID  <= q_inst[q_rd];
        pcOut_IFID    <= q_pc[q_rd];
      end else begin
        validOut_IFID <= 1'b0;
        instOut_IFID  <= NOP;
      end
    end
  end

`ifdef RVX_IF_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      misalignOut <= 1'b0;
    else
      misalignOut <= jumpEn && (jumpAddr[1:0] != 2'b00);
  end
`else
  assign misalignOut = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: boot, stall, redirects, PC wrap, misaligned target.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        jumpEn;
  logic [31:0] jumpAddr;
  logic        stall;
  logic [31:0] gnt_lim;
  int          lat;

  logic [31:0] instOut_IFID;
  logic [31:0] pcOut_IFID;
  logic        validOut_IFID;
  logic        misalignOut;

  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic        w_valid;
  logic        w_mis;

  int n_pass;
  int n_total;
  logic [31:0] exp_q[$];
  logic [31:0] wlog[$];

`ifdef RVX_IF_MISALIGN_CHK_EN
  localparam logic [31:0] EXP_MIS = 32'd1;
`else
  localparam logic [31:0] EXP_MIS = 32'd0;
`endif

  if_fetch_unit_if #(.BUS_W(32)) bus ();
  if_fetch_unit_if #(.BUS_W(32)) bus_w ();

  if_fetch_unit #(.BUS_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem(bus),
    .jumpEn(jumpEn), .jumpAddr(jumpAddr), .stall(stall),
    .instOut_IFID(instOut_IFID), .pcOut_IFID(pcOut_IFID),
    .validOut_IFID(validOut_IFID), .misalignOut(misalignOut)
  );

  if_fetch_unit #(.BUS_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem(bus_w),
    .jumpEn(1'b0), .jumpAddr(32'h0), .stall(1'b0),
    .instOut_IFID(w_inst), .pcOut_IFID(w_pc),
    .validOut_IFID(w_valid), .misalignOut(w_mis)
  );

  assign bus.imemGnt   = (bus.imemAddr < gnt_lim);
  assign bus_w.imemGnt = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: timed out, expected event never seen", name);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) timeout_fail(name);
    repeat (6) @(negedge clk);
  endtask

  // Memory model for the main DUT: grant-address model plus in-order delayed responses
  initial begin : mem_model
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_fetch;
    int          cyc;
    exp_fetch = 32'h0;
    cyc = 0;
    bus.imemRvalid = 1'b0;
    bus.imemRdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (jumpEn) exp_fetch = jumpAddr & 32'hFFFF_FFFC;
      if (rst && bus.imemReq && bus.imemGnt) begin
        check("fetch_addr", bus.imemAddr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        pend_addr.push_back(bus.imemAddr);
        pend_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
        bus.imemRvalid = 1'b1;
        bus.imemRdata  = imem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.imemRvalid = 1'b0;
      end
    end
  end

  // One-cycle memory for the wrap instance; logs its first two fetch addresses
  initial begin : wrap_mem
    logic        wfire;
    logic [31:0] waddr;
    bus_w.imemRvalid = 1'b0;
    bus_w.imemRdata  = 32'h0;
    forever begin
      @(negedge clk);
      wfire = rst && bus_w.imemReq;
      waddr = bus_w.imemAddr;
      if (wfire && wlog.size() < 2) wlog.push_back(waddr);
      @(posedge clk);
      #1;
      bus_w.imemRvalid = wfire;
      bus_w.imemRdata  = imem_word(waddr);
    end
  end

  // IF/ID monitor: a newly loaded instruction is valid with stall low in the previous cycle
  initial begin : monitor
    logic        stall_d;
    logic [31:0] pc_e;
    stall_d = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && validOut_IFID && !stall_d) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL ifid_unexpected: got pc %h, expected no instruction", pcOut_IFID);
        end else begin
          pc_e = exp_q.pop_front();
          check("ifid_pc", pcOut_IFID, pc_e);
          check("ifid_inst", instOut_IFID, imem_word(pc_e));
        end
      end
      stall_d = stall;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    int fires;
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    stall = 1'b0;
    jumpEn = 1'b0;
    jumpAddr = 32'h0;
    gnt_lim = 32'h40;
    lat = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, bus.imemReq}, 32'd0);
    check("rst_addr", bus.imemAddr, 32'h0);
    check("rst_inst", instOut_IFID, 32'h0000_0013);
    check("rst_pc", pcOut_IFID, 32'h0);
    check("rst_valid", {31'd0, validOut_IFID}, 32'd0);
    check("rst_misalign", {31'd0, misalignOut}, 32'd0);
    check("rst_addr_wrap", bus_w.imemAddr, 32'hFFFF_FFFC);

    // Boot and sequential stream 0x00..0x3C
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("boot_no_req", {31'd0, bus.imemReq}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, bus.imemReq}, 32'd1);
    check("first_addr", bus.imemAddr, 32'h0);
    @(negedge clk);
    check("second_addr", bus.imemAddr, 32'h4);
    @(negedge clk);
    check("third_addr", bus.imemAddr, 32'h8);
    check("valid_not_yet", {31'd0, validOut_IFID}, 32'd0);
    @(negedge clk);
    check("valid_rise", {31'd0, validOut_IFID}, 32'd1);

    // Five-cycle stall mid-stream
    @(posedge clk);
    #1 stall = 1'b1;
    repeat (5) @(negedge clk);
    check("stall_req_off", {31'd0, bus.imemReq}, 32'd0);
    check("stall_q_full", {30'd0, dut.q_cnt}, 32'd2);
    @(posedge clk);
    #1 stall = 1'b0;
    wait_drain("drain_stream");

    // Redirect with two outstanding, 3-cycle memory
    @(posedge clk);
    #1;
    lat = 3;
    gnt_lim = 32'h48;
    fires = 0;
    k = 0;
    while (fires < 2 && k < 20) begin
      @(negedge clk);
      if (bus.imemReq && bus.imemGnt) fires++;
      k++;
    end
    if (fires < 2) timeout_fail("two_outstanding");
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    jumpAddr = 32'h100;
    jumpEn = 1'b1;
    gnt_lim = 32'h110;
    @(posedge clk);
    #1 jumpEn = 1'b0;
    @(negedge clk);
    check("kill_cnt_two", {30'd0, dut.kill_cnt}, 32'd2);
    check("jump_valid_off", {31'd0, validOut_IFID}, 32'd0);
    check("drain_no_req", {31'd0, bus.imemReq}, 32'd0);
    @(negedge clk);
    check("drain_no_req2", {31'd0, bus.imemReq}, 32'd0);
    @(negedge clk);
    check("target_req", {31'd0, bus.imemReq}, 32'd1);
    check("target_addr", bus.imemAddr, 32'h100);
    wait_drain("drain_redirect");

    // Redirect with a response in the same cycle while stalled
    @(posedge clk);
    #1;
    lat = 1;
    gnt_lim = 32'h120;
    exp_q.push_back(32'h110);
    exp_q.push_back(32'h114);
    k = 0;
    while (!(validOut_IFID && bus.imemReq && bus.imemGnt) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) timeout_fail("valid_and_grant");
    @(posedge clk);
    #1;
    stall = 1'b1;
    jumpAddr = 32'h200;
    jumpEn = 1'b1;
    @(negedge clk);
    check("resp_in_jump_cycle", {31'd0, bus.imemRvalid}, 32'd1);
    @(posedge clk);
    #1 jumpEn = 1'b0;
    @(negedge clk);
    check("flush_over_stall", {31'd0, validOut_IFID}, 32'd0);
    check("flush_q_empty", {30'd0, dut.q_cnt}, 32'd0);
    check("flush_no_kill", {30'd0, dut.kill_cnt}, 32'd0);
    @(posedge clk);
    #1 stall = 1'b0;
    wait_drain("drain_flush");

    // Misaligned redirect target
    @(posedge clk);
    #1;
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h304);
    gnt_lim = 32'h308;
    jumpAddr = 32'h302;
    jumpEn = 1'b1;
    @(posedge clk);
    #1 jumpEn = 1'b0;
    @(negedge clk);
    check("misalign_pulse", {31'd0, misalignOut}, EXP_MIS);
    check("misalign_req", {31'd0, bus.imemReq}, 32'd1);
    check("misalign_addr", bus.imemAddr, 32'h300);
    @(negedge clk);
    check("misalign_clear", {31'd0, misalignOut}, 32'd0);
    wait_drain("drain_misalign");

    // PC wrap on the RESET_PC = 0xFFFF_FFFC instance
    if (wlog.size() < 2) begin
      timeout_fail("wrap_fetches");
    end else begin
      check("wrap_first", wlog[0], 32'hFFFF_FFFC);
      check("wrap_second", wlog[1], 32'h0000_0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
